// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-memory arbiter and its line-width peers.
// Optional feature macro consumed by mem_arbiter: MEM_ARB_URGENT_PORT0_EN.
package mem_arb_pkg;

    localparam int DEF_ADDR_BITS = 16;
    localparam int DEF_LINE_BITS = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Width of a port index; never below one bit so degenerate configs still elaborate.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after (last+1), wrapping
// explicitly at NUM_PORTS so non-power-of-two port counts are handled.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    localparam int IW = idx_bits(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IW-1:0]        last_i,
    output logic [NUM_PORTS-1:0] win_oh_o,
    output logic [IW-1:0]        win_idx_o,
    output logic                 any_o
);

    always_comb begin
        int cand;
        logic [IW-1:0] cidx;
        cand      = 0;
        cidx      = '0;
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = int'(last_i) + off;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cidx = IW'(cand);
            if (!any_o && req_i[cidx]) begin
                any_o           = 1'b1;
                win_oh_o[cidx]  = 1'b1;
                win_idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port line-memory arbiter: one transaction at a time, round-robin winner, one-cycle
// completion pulse. Define MEM_ARB_URGENT_PORT0_EN to make port 0 win whenever it requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    localparam int IW = idx_bits(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           port_req,
    input  logic [NUM_PORTS-1:0]           port_we,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] port_addr,
    input  logic [NUM_PORTS*LINE_BITS-1:0] port_wline,
    output logic [LINE_BITS-1:0]           port_rline,
    output logic [NUM_PORTS-1:0]           port_valid,
    output logic [NUM_PORTS-1:0]           port_grant,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_BITS-1:0]           mem_addr,
    output logic [LINE_BITS-1:0]           mem_wline,
    input  logic [LINE_BITS-1:0]           mem_rline,
    input  logic                           mem_valid,
    output arb_state_e                     dbg_state_o
);

    arb_state_e state_q, state_d;

    logic [NUM_PORTS-1:0] owner_q;
    logic [IW-1:0]        last_q;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0] wline_q;
    logic [LINE_BITS-1:0] rline_q;

    logic [NUM_PORTS-1:0] req_rr, pick_oh, win_oh;
    logic [IW-1:0]        pick_idx, win_idx;
    logic                 pick_any, win_any, upd_last;

    logic                 sel_we;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [LINE_BITS-1:0] sel_wline;

`ifdef MEM_ARB_URGENT_PORT0_EN
    // Port 0 bypasses the rotation and leaves last_q untouched so 1..N-1 keep their order.
    always_comb begin
        req_rr    = port_req;
        req_rr[0] = 1'b0;
        win_oh    = pick_oh;
        win_idx   = pick_idx;
        win_any   = pick_any;
        upd_last  = pick_any;
        if (port_req[0]) begin
            win_oh   = NUM_PORTS'(1);
            win_idx  = '0;
            win_any  = 1'b1;
            upd_last = 1'b0;
        end
    end
`else
    always_comb begin
        req_rr   = port_req;
        win_oh   = pick_oh;
        win_idx  = pick_idx;
        win_any  = pick_any;
        upd_last = pick_any;
    end
`endif

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
        .req_i     (req_rr),
        .last_i    (last_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wline = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_oh[i]) begin
                sel_we    = port_we[i];
                sel_addr  = port_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wline = port_wline[i*LINE_BITS +: LINE_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_any)   state_d = BUSY;
            BUSY:    if (mem_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        port_grant  = (state_q == BUSY) ? owner_q : '0;
        port_valid  = (state_q == RESP) ? owner_q : '0;
        mem_req     = (state_q == BUSY);
        mem_we      = (state_q == BUSY) && we_q;
        mem_addr    = addr_q;
        mem_wline   = wline_q;
        port_rline  = rline_q;
        dbg_state_o = state_q;
    end

    // Request fields are frozen at grant time; later requester changes never reach memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            if (state_q == IDLE && win_any) begin
                owner_q <= win_oh;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wline_q <= sel_wline;
                if (upd_last) begin
                    last_q <= win_idx;
                end
            end
            if (state_q == BUSY && mem_valid && !we_q) begin
                rline_q <= mem_rline;
            end
        end
    end

endmodule
